timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter WIDTH, default 24: counter and reload width in bits.
REQ-002 Parameter CHANNELS, default 4: number of independent timer channels, 1..16.
REQ-003 Parameter PRESCALE, default 4: clock divisor, used only when TIMER_BANK_PRESCALE_EN is defined.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  command strobe, sampled every clk.
REQ-007 wr_ch  in  4  target channel of the command.
REQ-008 wr_cmd  in  2  command code: 0 LOAD, 1 START, 2 STOP, 3 NOP.
REQ-009 wr_data  in  WIDTH  reload value for LOAD.
REQ-010 irq_clr  in  CHANNELS  per-channel sticky-IRQ clear.
REQ-011 count  out  CHANNELS*WIDTH  current counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 running  out  CHANNELS  channel enabled.
REQ-013 periodic  out  CHANNELS  channel mode, 1 periodic, 0 one-shot.
REQ-014 expire  out  CHANNELS  one-cycle pulse on terminal count.
REQ-015 irq  out  CHANNELS  sticky expiry flags; irq_any out 1 is the OR of irq.

Function
REQ-016 Commands take effect on the clk edge where wr_en=1; results are visible in the following cycle.
REQ-017 LOAD writes wr_data into the channel's reload register and its count; running is unchanged.
REQ-018 START sets running; wr_data[0] selects periodic (1) or one-shot (0); count is unchanged.
REQ-019 STOP clears running; count holds its value.
REQ-020 A wr_ch value >= CHANNELS, or wr_cmd=NOP, is ignored with no state change.
REQ-021 A running channel decrements by 1 on each tick (every clk, or each prescaler tick per REQ-032).
REQ-022 A tick at count==0 asserts expire for exactly one cycle and sets irq.
REQ-023 At that tick a periodic channel reloads count from the reload register and stays running.
REQ-024 At that tick a one-shot channel holds count=0 and clears running.
REQ-025 Expiry period = reload+1 ticks; reload=0 in periodic mode expires every tick.
REQ-026 If a command to a channel coincides with that channel's expiry tick, the command wins and expire/irq are suppressed for that tick.
REQ-027 If irq_clr[i] coincides with a new expiry on channel i, the set wins and irq[i] stays 1.
REQ-028 Channels are independent; a command to one channel never alters another.

Reset
REQ-029 While rst=1, all counts, reload registers, running, periodic, expire and irq are 0 on the next edge.
REQ-030 rst overrides any concurrent command, tick or irq_clr; reset mid-count gives count=0 the following cycle.
REQ-031 The prescaler counter resets to 0.

Configuration
REQ-032 With TIMER_BANK_PRESCALE_EN defined, one shared prescaler counts clk 0..PRESCALE-1 and produces a tick when it wraps to 0; it free-runs independent of channel state.
REQ-033 Without TIMER_BANK_PRESCALE_EN, a tick occurs every clk, no prescaler logic is synthesised, and PRESCALE is ignored.

Structure
REQ-034 Shared package timer_pkg holds the command-code typedef (LOAD/START/STOP/NOP) and the mode constants.
REQ-035 Sub-module timer_channel (one counter, reload register, mode, expire/irq logic) is instantiated CHANNELS times through a generate loop; timer_bank owns only command decode and the prescaler.

Verification
REQ-036 WIDTH=24, no prescale: LOAD ch0 5, START one-shot -> count 5,4,3,2,1,0; expire[0] pulses one cycle at the 0 tick; running[0]=0; count holds 0.
REQ-037 LOAD ch1 3, START periodic -> expire[1] pulses every 4 clks; irq[1] stays 1 until irq_clr[1], then 0 the next cycle.
REQ-038 Periodic ch2 at count 0 with LOAD 9 issued the same cycle -> no expire, count=9 next cycle.
REQ-039 All 4 channels running at count 0x000100, rst asserted for 1 cycle -> all outputs 0 the next cycle; wr_ch=7 LOAD is ignored.
REQ-040 TIMER_BANK_PRESCALE_EN, PRESCALE=4: LOAD 2, START one-shot -> expire after 12 clks (±3 by prescaler phase); count changes only on tick edges.
REQ-041 irq_clr[3] asserted in the same cycle as an expiry on ch3 -> irq[3]=1 and irq_any=1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the timer bank: command codes, channel modes and
// the per-channel control state.
package timer_pkg;

   typedef enum logic [1:0] {
      CMD_LOAD  = 2'd0,
      CMD_START = 2'd1,
      CMD_STOP  = 2'd2,
      CMD_NOP   = 2'd3
   } cmd_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter with reload register, one-shot or
// periodic mode, single-cycle expire pulse and sticky irq flag.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | stopped; count holds, ticks ignored
// ST_RUN  | counting down one per tick; terminal count at zero
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             cmd_valid,
   input  cmd_t             cmd,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             periodic,
   output logic             expire,
   output logic             irq
);

   chan_state_t      state, state_nxt;
   logic [WIDTH-1:0] reload, reload_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             periodic_nxt;
   logic             expire_nxt;
   logic             irq_nxt;

   // state and datapath registers; reset clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         reload   <= '0;
         count    <= '0;
         periodic <= MODE_ONESHOT;
         expire   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         state    <= state_nxt;
         reload   <= reload_nxt;
         count    <= count_nxt;
         periodic <= periodic_nxt;
         expire   <= expire_nxt;
         irq      <= irq_nxt;
      end
   end

   // next-state: a command beats a coincident tick, and an expiry beats irq_clr
   always_comb begin
      state_nxt    = state;
      reload_nxt   = reload;
      count_nxt    = count;
      periodic_nxt = periodic;
      expire_nxt   = 1'b0;
      irq_nxt      = irq & ~irq_clr;
      if (cmd_valid) begin
         case (cmd)
            CMD_LOAD: begin
               reload_nxt = wr_data;
               count_nxt  = wr_data;
            end
            CMD_START: begin
               state_nxt    = ST_RUN;
               periodic_nxt = wr_data[0];
            end
            CMD_STOP: state_nxt = ST_IDLE;
            default: ;
         endcase
      end else if (state == ST_RUN && tick) begin
         if (count == '0) begin
            expire_nxt = 1'b1;
            irq_nxt    = 1'b1;
            if (periodic == MODE_PERIODIC) begin
               count_nxt = reload;
            end else begin
               count_nxt = '0;
               state_nxt = ST_IDLE;
            end
         end else begin
            count_nxt = count - WIDTH'(1);
         end
      end
   end

   assign running = (state == ST_RUN);

endmodule

// File: rtl/timer_bank.sv
// Bank of independent down-counting timers. The top decodes the command
// strobe into per-channel enables and generates the shared count tick.
// Optional macro TIMER_BANK_PRESCALE_EN: ticks come from a free-running
// divide-by-PRESCALE counter instead of every clock.
module timer_bank
   import timer_pkg::*;
#(
   parameter int WIDTH    = 24,
   parameter int CHANNELS = 4,
   parameter int PRESCALE = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [3:0]                wr_ch,
   input  logic [1:0]                wr_cmd,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [CHANNELS-1:0]       irq_clr,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       running,
   output logic [CHANNELS-1:0]       periodic,
   output logic [CHANNELS-1:0]       expire,
   output logic [CHANNELS-1:0]       irq,
   output logic                      irq_any
);

   if (CHANNELS < 1 || CHANNELS > 16 || PRESCALE < 1) begin : g_bad_param
      $error("timer_bank: CHANNELS must be 1..16 and PRESCALE must be >= 1");
   end

   cmd_t                cmd_dec;
   logic                tick;
   logic [CHANNELS-1:0] cmd_valid;

   assign cmd_dec = cmd_t'(wr_cmd);

`ifdef TIMER_BANK_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] presc_cnt;

   // free-running divider, tick on the cycle that wraps back to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_cnt <= '0;
      end else if (presc_cnt == PW'(PRESCALE - 1)) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + PW'(1);
      end
   end

   assign tick = (presc_cnt == PW'(PRESCALE - 1));
`else
   assign tick = 1'b1;
`endif

   // address decode: an out-of-range channel matches nothing, NOP reaches nobody
   always_comb begin
      cmd_valid = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cmd_valid[i] = wr_en && (cmd_dec != CMD_NOP) && (wr_ch == 4'(i));
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      timer_channel #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick),
         .cmd_valid (cmd_valid[i]),
         .cmd       (cmd_dec),
         .wr_data   (wr_data),
         .irq_clr   (irq_clr[i]),
         .count     (count[i*WIDTH +: WIDTH]),
         .running   (running[i]),
         .periodic  (periodic[i]),
         .expire    (expire[i]),
         .irq       (irq[i])
      );
   end

   assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank in its default build (tick every clock).
// Inputs change and outputs are sampled on the falling edge.
module tb_timer_bank;
   import timer_pkg::*;

   localparam int W  = 24;
   localparam int CH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en;
   logic [3:0]      wr_ch;
   logic [1:0]      wr_cmd;
   logic [W-1:0]    wr_data;
   logic [CH-1:0]   irq_clr;
   logic [CH*W-1:0] count;
   logic [CH-1:0]   running;
   logic [CH-1:0]   periodic;
   logic [CH-1:0]   expire;
   logic [CH-1:0]   irq;
   logic            irq_any;

   int n_chk  = 0;
   int n_pass = 0;

   timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_ch    (wr_ch),
      .wr_cmd   (wr_cmd),
      .wr_data  (wr_data),
      .irq_clr  (irq_clr),
      .count    (count),
      .running  (running),
      .periodic (periodic),
      .expire   (expire),
      .irq      (irq),
      .irq_any  (irq_any)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] cnt(input int ch);
      return count[ch*W +: W];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic issue(input int ch, input cmd_t c, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_ch   = 4'(ch);
      wr_cmd  = c;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
      wr_cmd  = CMD_NOP;
      wr_data = '0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_cmd = CMD_NOP;
      wr_data = '0; irq_clr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_count",    64'(count),    64'h0);
      chk("rst_running",  64'(running),  64'h0);
      chk("rst_periodic", 64'(periodic), 64'h0);
      chk("rst_expire",   64'(expire),   64'h0);
      chk("rst_irq",      64'({irq_any, irq}), 64'h0);

      // one-shot ch0 from 5
      issue(0, CMD_LOAD, 24'd5);
      chk("os_load_count", 64'(cnt(0)), 64'd5);
      chk("os_load_run",   64'(running[0]), 64'd0);
      issue(0, CMD_START, 24'd0);
      chk("os_start_count", 64'(cnt(0)), 64'd5);
      chk("os_start_run",   64'(running[0]), 64'd1);
      chk("os_start_per",   64'(periodic[0]), 64'd0);
      for (int k = 4; k >= 0; k--) begin
         @(negedge clk);
         chk("os_count", 64'(cnt(0)), 64'(k));
         chk("os_no_exp", 64'(expire[0]), 64'd0);
      end
      @(negedge clk);
      chk("os_expire",   64'(expire[0]), 64'd1);
      chk("os_irq",      64'(irq[0]), 64'd1);
      chk("os_stopped",  64'(running[0]), 64'd0);
      chk("os_hold0",    64'(cnt(0)), 64'd0);
      @(negedge clk);
      chk("os_exp_once", 64'(expire[0]), 64'd0);
      chk("os_hold0b",   64'(cnt(0)), 64'd0);
      irq_clr = 4'b0001;
      @(negedge clk);
      irq_clr = '0;
      chk("os_irq_clr", 64'(irq[0]), 64'd0);

      // periodic ch1 reload 3: expire every 4 clocks
      issue(1, CMD_LOAD, 24'd3);
      issue(1, CMD_START, 24'd1);
      chk("per_start_count", 64'(cnt(1)), 64'd3);
      chk("per_mode", 64'(periodic[1]), 64'd1);
      for (int p = 0; p < 3; p++) begin
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("per_expire", 64'(expire[1]), 64'(j == 3));
         end
      end
      chk("per_irq_sticky", 64'(irq[1]), 64'd1);
      chk("per_reloaded", 64'(cnt(1)), 64'd3);
      irq_clr = 4'b0010;
      @(negedge clk);
      irq_clr = '0;
      chk("per_irq_clr", 64'(irq[1]), 64'd0);
      issue(1, CMD_STOP, 24'd0);
      chk("stop_run",  64'(running[1]), 64'd0);
      chk("stop_hold", 64'(cnt(1)), 64'd2);
      repeat (2) @(negedge clk);
      chk("stop_hold2", 64'(cnt(1)), 64'd2);

      // irq_clr coinciding with ch3 expiry: set wins
      issue(3, CMD_LOAD, 24'd2);
      issue(3, CMD_START, 24'd0);
      repeat (2) @(negedge clk);
      chk("clr_pre_count", 64'(cnt(3)), 64'd0);
      irq_clr = 4'b1000;
      @(negedge clk);
      irq_clr = '0;
      chk("clr_race_exp", 64'(expire[3]), 64'd1);
      chk("clr_race_irq", 64'(irq[3]), 64'd1);
      chk("clr_race_any", 64'(irq_any), 64'd1);
      irq_clr = 4'b1000;
      @(negedge clk);
      irq_clr = '0;
      chk("clr_after_any", 64'({irq_any, irq}), 64'h0);

      // command coinciding with ch2 expiry tick: command wins
      issue(2, CMD_LOAD, 24'd2);
      issue(2, CMD_START, 24'd1);
      repeat (2) @(negedge clk);
      chk("race_pre_count", 64'(cnt(2)), 64'd0);
      issue(2, CMD_LOAD, 24'd9);
      chk("race_count", 64'(cnt(2)), 64'd9);
      chk("race_no_exp", 64'(expire[2]), 64'd0);
      chk("race_no_irq", 64'(irq[2]), 64'd0);
      chk("race_running", 64'(running[2]), 64'd1);
      issue(2, CMD_STOP, 24'd0);
      chk("race_stop_count", 64'(cnt(2)), 64'd9);

      // out-of-range channel and NOP are ignored
      issue(7, CMD_LOAD, 24'h123);
      issue(0, CMD_NOP, 24'h55);
      chk("ign_count", 64'(count), 64'({24'd0, 24'd9, 24'd2, 24'd0}));
      chk("ign_running", 64'(running), 64'h0);

      // all channels running, ch0 reload 0 expires every tick, then reset
      issue(0, CMD_LOAD, 24'd0);
      issue(1, CMD_LOAD, 24'h000100);
      issue(2, CMD_LOAD, 24'h000100);
      issue(3, CMD_LOAD, 24'h000100);
      issue(0, CMD_START, 24'd1);
      issue(1, CMD_START, 24'd1);
      issue(2, CMD_START, 24'd1);
      issue(3, CMD_START, 24'd1);
      chk("r0_expire_a", 64'(expire[0]), 64'd1);
      @(negedge clk);
      chk("r0_expire_b", 64'(expire[0]), 64'd1);
      chk("all_running", 64'(running), 64'hf);
      chk("ch1_count",   64'(cnt(1)), 64'h0000fd);
      chk("pre_rst_irq", 64'(irq), 64'h1);
      rst = 1'b1; wr_en = 1'b1; wr_ch = 4'd1; wr_cmd = CMD_LOAD;
      wr_data = 24'h55; irq_clr = 4'hf;
      @(negedge clk);
      rst = 1'b0; wr_en = 1'b0; wr_cmd = CMD_NOP; wr_data = '0; irq_clr = '0;
      chk("mid_rst_count",   64'(count), 64'h0);
      chk("mid_rst_running", 64'(running), 64'h0);
      chk("mid_rst_per",     64'(periodic), 64'h0);
      chk("mid_rst_exp",     64'(expire), 64'h0);
      chk("mid_rst_irq",     64'({irq_any, irq}), 64'h0);
      issue(7, CMD_LOAD, 24'h123);
      chk("post_rst_ign", 64'(count), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
